maze_run_sequencer: RTL and testbench

Session-level sequencer for the rat-in-maze solver. Loads a maze from a host row stream into the 1-bit-per-cell maze memory, and owns the memory port arbitration between itself (load phase) and the solver controller (solve phase). Launches the solver, watches for done/fail with a cycle-limit watchdog, and reports the result. Sits above the solver controller, datapath and maze memory in the top level.

---
 rtl/maze_pkg.sv | 29 ++
 rtl/maze_mem_mux.sv | 48 ++++
 rtl/maze_run_sequencer.sv | 179 +++++++++++++++++
 tb/tb_maze_run_sequencer.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/maze_pkg.sv
// Shared definitions for the maze run sequencer slice.
// Provides the default maze geometry, the sequencer state encoding and
// the {row,col} cell-address helper used to index the 1-bit-per-cell maze
// memory.
package maze_pkg;

    localparam int ROWS  = 16;
    localparam int COLS  = 16;
    localparam int ROW_W = $clog2(ROWS);
    localparam int COL_W = $clog2(COLS);
    localparam int LOC_W = ROW_W + COL_W;
    localparam int CNT_W = 16;

    // Sequencer state encoding; also driven out on the debug state port.
    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE       = 3'd0;
    localparam state_t ST_LOAD_WAIT  = 3'd1;
    localparam state_t ST_LOAD_WRITE = 3'd2;
    localparam state_t ST_START      = 3'd3;
    localparam state_t ST_SOLVE      = 3'd4;
    localparam state_t ST_RESULT     = 3'd5;

    // Cell address: row in the upper bits, column in the lower bits.
    function automatic logic [LOC_W-1:0] maze_loc(input logic [ROW_W-1:0] row,
                                                  input logic [COL_W-1:0] col);
        return {row, col};
    endfunction

endpackage

// File: rtl/maze_mem_mux.sv
// Maze memory port arbiter.
// Selects between the sequencer's load-phase write port and the solver's
// port. Solver strobes are forwarded, and read data returned, only while
// the solver is live; otherwise the solver sees 0 and its strobes are dropped.
// Ports:
//   grant     solver owns the address/data path (START and SOLVE)
//   sol_live  solver strobes forwarded and read data returned (SOLVE only)
//   seq_*     sequencer load port (write only)
//   sol_*     solver port in, sol_dout back to solver
//   mem_*     maze memory port
module maze_mem_mux #(
    parameter int LOC_W = 8
) (
    input  logic             grant,
    input  logic             sol_live,
    input  logic [LOC_W-1:0] seq_loc,
    input  logic             seq_wr,
    input  logic             seq_din,
    input  logic [LOC_W-1:0] sol_loc,
    input  logic             sol_rd,
    input  logic             sol_wr,
    input  logic             sol_din,
    output logic             sol_dout,
    output logic [LOC_W-1:0] mem_loc,
    output logic             mem_rd,
    output logic             mem_wr,
    output logic             mem_din,
    input  logic             mem_dout
);

    always_comb begin
        mem_loc  = seq_loc;
        mem_din  = seq_din;
        mem_rd   = 1'b0;
        mem_wr   = seq_wr;
        sol_dout = 1'b0;
        if (grant) begin
            mem_loc = sol_loc;
            mem_din = sol_din;
            mem_rd  = sol_live & sol_rd;
            mem_wr  = sol_live & sol_wr;
        end
        if (sol_live) begin
            sol_dout = mem_dout;
        end
    end

endmodule

// File: rtl/maze_run_sequencer.sv
// Session-level sequencer for the rat-in-maze solver.
// Loads a maze row by row from the host into the maze memory, hands the
// memory port to the solver, launches it, watches done/fail under a cycle
// watchdog and holds the result until the next session or an abort.
// Handshake: a row transfers on a rising edge where row_valid and row_ready
// are both 1; row_ready depends only on state, never on row_valid.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   host_start, abort     session control from the host
//   row_valid/ready/data  host row stream, bit c of row_data = cell (row,c)
//   sol_*                 solver memory port and control/status
//   mem_*                 maze memory port
//   busy, result_*        session status and result
//   cycle_count           solve cycles elapsed (saturating)
//   state                 current sequencer state (debug)
module maze_run_sequencer #(
    parameter int                          ROWS        = maze_pkg::ROWS,
    parameter int                          COLS        = maze_pkg::COLS,
    parameter int                          LOC_W       = maze_pkg::LOC_W,
    parameter int                          CNT_W       = maze_pkg::CNT_W,
    parameter logic [CNT_W-1:0]            CYCLE_LIMIT = {CNT_W{1'b1}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             host_start,
    input  logic             abort,
    input  logic             row_valid,
    output logic             row_ready,
    input  logic [COLS-1:0]  row_data,
    input  logic [LOC_W-1:0] sol_loc,
    input  logic             sol_rd,
    input  logic             sol_wr,
    input  logic             sol_din,
    output logic             sol_dout,
    output logic [LOC_W-1:0] mem_loc,
    output logic             mem_rd,
    output logic             mem_wr,
    output logic             mem_din,
    input  logic             mem_dout,
    output logic             sol_start,
    output logic             sol_abort,
    input  logic             sol_done,
    input  logic             sol_fail,
    output logic             busy,
    output logic             result_valid,
    output logic             result_found,
    output logic             result_timeout,
    output logic [CNT_W-1:0] cycle_count,
    output logic [2:0]       state
);

    import maze_pkg::*;

    localparam int R_W = $clog2(ROWS);
    localparam int C_W = $clog2(COLS);

    state_t           state_q;
    logic [R_W-1:0]   row_q;
    logic [C_W-1:0]   col_q;
    logic [COLS-1:0]  row_buf;
    logic             found_q;
    logic             timeout_q;
    logic [CNT_W-1:0] count_q;

    logic             in_solve;
    logic             grant;
    logic [CNT_W-1:0] count_inc;
    logic             limit_hit;

    assign in_solve  = (state_q == ST_SOLVE);
    assign grant     = (state_q == ST_START) || in_solve;
    assign count_inc = (count_q == {CNT_W{1'b1}}) ? count_q : count_q + CNT_W'(1);
    // The cycle that brings the count to the limit is the last allowed one;
    // a done/fail reported in that same cycle takes precedence.
    assign limit_hit = in_solve && !sol_done && !sol_fail && (count_inc == CYCLE_LIMIT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            row_q     <= '0;
            col_q     <= '0;
            row_buf   <= '0;
            found_q   <= 1'b0;
            timeout_q <= 1'b0;
            count_q   <= '0;
        end else if (abort) begin
            state_q   <= ST_IDLE;
            row_q     <= '0;
            col_q     <= '0;
            found_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_RESULT: begin
                    if (host_start) begin
                        state_q   <= ST_LOAD_WAIT;
                        row_q     <= '0;
                        col_q     <= '0;
                        found_q   <= 1'b0;
                        timeout_q <= 1'b0;
                        count_q   <= '0;
                    end
                end
                ST_LOAD_WAIT: begin
                    if (row_valid) begin
                        row_buf <= row_data;
                        col_q   <= '0;
                        state_q <= ST_LOAD_WRITE;
                    end
                end
                ST_LOAD_WRITE: begin
                    if (col_q == {C_W{1'b1}}) begin
                        col_q <= '0;
                        if (row_q == {R_W{1'b1}}) begin
                            row_q   <= '0;
                            state_q <= ST_START;
                        end else begin
                            row_q   <= row_q + R_W'(1);
                            state_q <= ST_LOAD_WAIT;
                        end
                    end else begin
                        col_q <= col_q + C_W'(1);
                    end
                end
                ST_START: begin
                    state_q <= ST_SOLVE;
                end
                ST_SOLVE: begin
                    count_q <= count_inc;
                    if (sol_done) begin
                        found_q <= 1'b1;
                        state_q <= ST_RESULT;
                    end else if (sol_fail) begin
                        state_q <= ST_RESULT;
                    end else if (limit_hit) begin
                        timeout_q <= 1'b1;
                        state_q   <= ST_RESULT;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign row_ready      = (state_q == ST_LOAD_WAIT);
    assign sol_start      = (state_q == ST_START);
    // The solver is reset both on a host abort while it owns the memory and
    // on the watchdog cycle.
    assign sol_abort      = (abort && grant) || limit_hit;
    assign busy           = (state_q == ST_LOAD_WAIT) || (state_q == ST_LOAD_WRITE) || grant;
    assign result_valid   = (state_q == ST_RESULT);
    assign result_found   = found_q;
    assign result_timeout = timeout_q;
    assign cycle_count    = count_q;
    assign state          = state_q;

    maze_mem_mux #(
        .LOC_W (LOC_W)
    ) u_mux (
        .grant    (grant),
        .sol_live (in_solve),
        .seq_loc  ({row_q, col_q}),
        .seq_wr   (state_q == ST_LOAD_WRITE),
        .seq_din  (row_buf[col_q]),
        .sol_loc  (sol_loc),
        .sol_rd   (sol_rd),
        .sol_wr   (sol_wr),
        .sol_din  (sol_din),
        .sol_dout (sol_dout),
        .mem_loc  (mem_loc),
        .mem_rd   (mem_rd),
        .mem_wr   (mem_wr),
        .mem_din  (mem_din),
        .mem_dout (mem_dout)
    );

endmodule

// File: tb/tb_maze_run_sequencer.sv
module tb_maze_run_sequencer;
    import maze_pkg::*;

    localparam int W = LOC_W + 1;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic             host_start, abort, row_valid, row_ready;
    logic [COLS-1:0]  row_data;
    logic [LOC_W-1:0] sol_loc;
    logic             sol_rd, sol_wr, sol_din, sol_dout;
    logic [LOC_W-1:0] mem_loc;
    logic             mem_rd, mem_wr, mem_din, mem_dout;
    logic             sol_start, sol_abort, sol_done, sol_fail;
    logic             busy, result_valid, result_found, result_timeout;
    logic [CNT_W-1:0] cycle_count;
    logic [2:0]       state;

    maze_run_sequencer #(
        .ROWS        (16),
        .COLS        (16),
        .LOC_W       (8),
        .CNT_W       (16),
        .CYCLE_LIMIT (16'd20)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .host_start     (host_start),
        .abort          (abort),
        .row_valid      (row_valid),
        .row_ready      (row_ready),
        .row_data       (row_data),
        .sol_loc        (sol_loc),
        .sol_rd         (sol_rd),
        .sol_wr         (sol_wr),
        .sol_din        (sol_din),
        .sol_dout       (sol_dout),
        .mem_loc        (mem_loc),
        .mem_rd         (mem_rd),
        .mem_wr         (mem_wr),
        .mem_din        (mem_din),
        .mem_dout       (mem_dout),
        .sol_start      (sol_start),
        .sol_abort      (sol_abort),
        .sol_done       (sol_done),
        .sol_fail       (sol_fail),
        .busy           (busy),
        .result_valid   (result_valid),
        .result_found   (result_found),
        .result_timeout (result_timeout),
        .cycle_count    (cycle_count),
        .state          (state)
    );

    // ---------------- scoreboard state ----------------
    int n_checks = 0;
    int n_pass   = 0;
    logic [W-1:0] exp_q[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    // ---------------- memory model and monitors ----------------
    logic mem [0:(1<<LOC_W)-1];
    assign mem_dout = mem[mem_loc];

    logic [COLS-1:0] rows_tbl [0:ROWS-1];
    int rows_sent = 0;
    assign row_data = rows_tbl[rows_sent[ROW_W-1:0]];

    int start_cnt = 0;
    int abort_cnt = 0;

    always @(posedge clk) begin
        if (host_start) rows_sent <= 0;
        else if (row_valid && row_ready) rows_sent <= rows_sent + 1;
        if (sol_start) start_cnt++;
        if (sol_abort) abort_cnt++;
        if (mem_wr) begin
            mem[mem_loc] <= mem_din;
            if (exp_q.size() == 0) check_eq("wr_extra", mem_wr, 0);
            else check_eq("wr_seq", {mem_loc, mem_din}, exp_q.pop_front());
        end
    end

    function automatic int ones_in_mem();
        int n = 0;
        for (int i = 0; i < (1 << LOC_W); i++) n += int'(mem[i]);
        return n;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic fill_exp();
        exp_q.delete();
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                logic [COLS-1:0] rw;
                rw = rows_tbl[r];
                exp_q.push_back({maze_loc(ROW_W'(r), COL_W'(c)), rw[c]});
            end
        end
    endtask

    task automatic pulse_host_start();
        @(posedge clk); #1 host_start = 1'b1;
        @(posedge clk); #1 host_start = 1'b0;
        check_eq("clr_valid", result_valid, 0);
        check_eq("clr_found", result_found, 0);
        check_eq("clr_count", cycle_count, 0);
    endtask

    // Returns at the falling edge of the START cycle.
    task automatic run_load(input bit gapped, output int cycles);
        int s0;
        s0 = start_cnt;
        fill_exp();
        sol_loc = 8'h55; sol_wr = 1'b1; sol_din = 1'b1; sol_rd = 1'b1;
        pulse_host_start();
        cycles = 0;
        while (cycles < 4000) begin
            row_valid = gapped ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            if (state == ST_START) break;
            if (state == ST_LOAD_WRITE && mem_loc == 8'h03) begin
                check_eq("load_sol_dout", sol_dout, 0);
                check_eq("load_mem_rd", mem_rd, 0);
                check_eq("load_row_ready", row_ready, 0);
            end
            cycles++;
            @(posedge clk); #1;
        end
        row_valid = 1'b0; sol_wr = 1'b0; sol_rd = 1'b0; sol_din = 1'b0;
        check_eq("load_to_start", state, ST_START);
        check_eq("start_pulse", sol_start, 1);
        check_eq("start_first", start_cnt - s0, 0);
        check_eq("load_drain", exp_q.size(), 0);
        check_eq("cell_30", mem[8'h30], 1);
        check_eq("cell_3f", mem[8'h3f], 1);
        check_eq("cell_55", mem[8'h55], 0);
        check_eq("mem_ones", ones_in_mem(), 2);
    endtask

    // Assert done/fail in SOLVE cycle k (called at the START falling edge).
    task automatic solve_pulse(input int k, input logic d, input logic f);
        int a0;
        a0 = abort_cnt;
        repeat (k) @(posedge clk);
        #1 sol_done = d; sol_fail = f;
        @(posedge clk); #1 sol_done = 1'b0; sol_fail = 1'b0;
        @(negedge clk);
        check_eq("no_sol_abort", abort_cnt - a0, 0);
    endtask

    task automatic check_result(input string tag, input logic f, input logic t, input int cnt);
        check_eq({tag, "_valid"}, result_valid, 1);
        check_eq({tag, "_found"}, result_found, f);
        check_eq({tag, "_timeout"}, result_timeout, t);
        check_eq({tag, "_count"}, cycle_count, cnt);
        check_eq({tag, "_busy"}, busy, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        int cyc, s, a0, s0;
        rst = 1'b1; host_start = 1'b0; abort = 1'b0; row_valid = 1'b0;
        sol_loc = '0; sol_rd = 1'b0; sol_wr = 1'b0; sol_din = 1'b0;
        sol_done = 1'b0; sol_fail = 1'b0;
        for (int i = 0; i < (1 << LOC_W); i++) mem[i] = 1'b1;
        for (int r = 0; r < ROWS; r++) rows_tbl[r] = (r == 3) ? 16'h8001 : 16'h0000;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_state", state, ST_IDLE);
        check_eq("rst_row_ready", row_ready, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_valid", result_valid, 0);
        check_eq("rst_mem_wr", mem_wr, 0);
        check_eq("rst_sol_start", sol_start, 0);
        check_eq("rst_sol_abort", sol_abort, 0);
        check_eq("rst_count", cycle_count, 0);
        @(posedge clk); #1 rst = 1'b0;

        // Session A: full-rate load, forwarding in SOLVE, done after 10 cycles
        s0 = start_cnt;
        run_load(1'b0, cyc);
        check_eq("load_cycles", cyc, 272);
        @(posedge clk); #1 sol_rd = 1'b1; sol_loc = 8'h30;
        @(negedge clk);
        check_eq("solve_start_low", sol_start, 0);
        check_eq("start_once", start_cnt - s0, 1);
        check_eq("fwd_mem_rd", mem_rd, 1);
        check_eq("fwd_mem_loc", mem_loc, 8'h30);
        check_eq("fwd_dout_1", sol_dout, 1);
        check_eq("fwd_mem_wr", mem_wr, 0);
        @(posedge clk); #1 sol_loc = 8'h31;
        @(negedge clk);
        check_eq("fwd_dout_0", sol_dout, 0);
        repeat (8) @(posedge clk);
        #1 sol_done = 1'b1; sol_rd = 1'b0;
        @(negedge clk);
        check_eq("solve_busy", busy, 1);
        @(posedge clk); #1 sol_done = 1'b0;
        @(negedge clk);
        check_result("doneA", 1'b1, 1'b0, 10);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("hold_found", result_found, 1);

        // Session B: done and fail together
        run_load(1'b0, cyc);
        solve_pulse(5, 1'b1, 1'b1);
        check_result("both", 1'b1, 1'b0, 5);

        // Session C: fail only
        run_load(1'b0, cyc);
        solve_pulse(7, 1'b0, 1'b1);
        check_result("fail", 1'b0, 1'b0, 7);

        // Session D: silent solver, watchdog at 20 cycles
        run_load(1'b0, cyc);
        a0 = abort_cnt; s = 0;
        while (s < 60) begin
            @(posedge clk); #1;
            @(negedge clk);
            if (state != ST_SOLVE) break;
            s++;
        end
        check_eq("to_solve_cycles", s, 20);
        check_eq("to_abort_pulses", abort_cnt - a0, 1);
        check_result("timeout", 1'b0, 1'b1, 20);

        // Session E: done on the limit cycle beats the watchdog
        run_load(1'b0, cyc);
        solve_pulse(20, 1'b1, 1'b0);
        check_result("limit_done", 1'b1, 1'b0, 20);

        // Session F: gapped rows, abort inside row 7 write burst
        fill_exp();
        sol_loc = 8'h55; sol_wr = 1'b1; sol_din = 1'b1;
        pulse_host_start();
        cyc = 0;
        while (cyc < 4000) begin
            row_valid = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (state == ST_LOAD_WRITE && mem_loc == 8'h73) break;
            cyc++;
            @(posedge clk); #1;
        end
        check_eq("abort_reach_row7", mem_loc, 8'h73);
        abort = 1'b1;
        #1 check_eq("abort_load_sol_abort", sol_abort, 0);
        @(posedge clk); #1 abort = 1'b0; row_valid = 1'b1; sol_wr = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check_eq("abort_state", state, ST_IDLE);
        check_eq("abort_row_ready", row_ready, 0);
        check_eq("abort_mem_wr", mem_wr, 0);
        check_eq("abort_busy", busy, 0);
        repeat (5) @(posedge clk);
        #1 row_valid = 1'b0;

        // Reload from row 0 with gaps, then abort during SOLVE
        run_load(1'b1, cyc);
        a0 = abort_cnt;
        repeat (3) @(posedge clk);
        @(negedge clk);
        abort = 1'b1;
        #1 check_eq("abort_solve_sol_abort", sol_abort, 1);
        @(posedge clk); #1 abort = 1'b0;
        @(negedge clk);
        check_eq("abort2_state", state, ST_IDLE);
        check_eq("abort2_valid", result_valid, 0);
        check_eq("abort2_pulses", abort_cnt - a0, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
